// File: rtl/mem_pkg.sv
// Shared definitions for the word-memory controller and its memory.
//   state_t : controller FSM encoding (3-bit)
//   ADDR_W  : memory address width
//   DEF_W   : default data MSB index (data width DEF_W+1)
//   DEF_L   : default number of valid memory locations
package mem_pkg;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DEF_W  = 7;
    localparam int unsigned DEF_L  = 10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } state_t;

endpackage

// File: rtl/mem_ctrl.sv
// Sequencer owning the word memory's command interface. Turns write/read
// requests (valid/ready) into single-cycle memory commands and returns
// registered read data over a valid/ready response channel. Requests to
// addresses >= l, and writes of zero data, are dropped with an err pulse.
//   clk, reset            : clock (rising edge), async active-high reset
//   wr_valid/wr_ready     : write request handshake, wr_addr/wr_data payload
//   rd_req_valid/_ready   : read request handshake, rd_addr payload
//   rd_valid/rd_ready     : read response handshake, rd_data payload
//   err                   : one-cycle pulse when a request is dropped
//   mem_write/add/enable  : memory command outputs
//   mem_out               : memory registered read data
module mem_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned w = DEF_W,
    parameter int unsigned l = DEF_L
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [w:0]        wr_data,
    input  logic              rd_req_valid,
    output logic              rd_req_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [w:0]        rd_data,
    output logic              err,
    output logic [w:0]        mem_write,
    output logic [ADDR_W-1:0] mem_add,
    output logic              mem_enable,
    input  logic [w:0]        mem_out
);

    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(l);

    state_t            state, state_nxt;
    logic              live;       // low until the first clock after reset
    logic [ADDR_W-1:0] addr_q;
    logic [w:0]        data_q;
    logic              wr_fire, rd_fire, wr_ok, rd_ok;

    assign wr_ok   = ({1'b0, wr_addr} < LIMIT) && (wr_data != '0);
    assign rd_ok   = ({1'b0, rd_addr} < LIMIT);
    assign wr_fire = wr_valid && wr_ready;
    assign rd_fire = rd_req_valid && rd_req_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wr_ready     = 1'b0;
        rd_req_ready = 1'b0;
        mem_enable   = 1'b0;
        mem_write    = '0;
        mem_add      = '0;
        case (state)
            IDLE: begin
                // Writes win over a simultaneous read request.
                wr_ready     = live;
                rd_req_ready = live && !wr_valid;
                if (wr_fire) begin
                    if (wr_ok) state_nxt = WRITE;
                end else if (rd_fire) begin
                    if (rd_ok) state_nxt = READ;
                end
            end
            WRITE: begin
                mem_enable = 1'b1;
                mem_add    = addr_q;
                mem_write  = data_q;
                state_nxt  = IDLE;
            end
            READ: begin
                mem_add   = addr_q;
                state_nxt = WAIT;
            end
            WAIT: state_nxt = RESP;
            RESP: if (rd_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            live     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            err      <= 1'b0;
        end else begin
            live <= 1'b1;
            err  <= (wr_fire && !wr_ok) || (rd_fire && !rd_ok);
            // Only legal requests are latched, so an illegal address can
            // never reach mem_add.
            if (wr_fire && wr_ok) begin
                addr_q <= wr_addr;
                data_q <= wr_data;
            end else if (rd_fire && rd_ok) begin
                addr_q <= rd_addr;
            end
            if (state == WAIT) begin
                rd_data  <= mem_out;
                rd_valid <= 1'b1;
            end else if (state == RESP && rd_ready) begin
                rd_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl with a behavioural 16-word memory.
// Expected read data comes from a bench-side memory model and is queued on
// each accepted legal read; the monitor pops and compares on every
// response handshake.
module tb_mem_ctrl;
    import mem_pkg::*;

    localparam int unsigned W = 7;
    localparam int unsigned L = 10;

    logic         clk = 1'b0;
    logic         reset;
    logic         wr_valid, wr_ready;
    logic [3:0]   wr_addr;
    logic [W:0]   wr_data;
    logic         rd_req_valid, rd_req_ready;
    logic [3:0]   rd_addr;
    logic         rd_valid, rd_ready;
    logic [W:0]   rd_data;
    logic         err;
    logic [W:0]   mem_write;
    logic [3:0]   mem_add;
    logic         mem_enable;
    logic [W:0]   mem_out;

    mem_ctrl #(.w(W), .l(L)) dut (
        .clk(clk), .reset(reset),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_addr(rd_addr),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .err(err), .mem_write(mem_write), .mem_add(mem_add),
        .mem_enable(mem_enable), .mem_out(mem_out)
    );

    always #5 clk = ~clk;

    // Memory: writes on enable with non-zero data, otherwise registers a read.
    logic [W:0] mem [16];
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
            mem_out <= '0;
        end else if (mem_enable && mem_write != '0) begin
            mem[mem_add] <= mem_write;
        end else begin
            mem_out <= mem[mem_add];
        end
    end

    logic [W:0]  model [16];
    logic [W:0]  sb [$];
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned en_cnt = 0, err_cnt = 0, rv_cnt = 0, bad_addr = 0;
    logic [3:0]  en_addr;
    logic [W:0]  en_data;
    logic        rv_prev = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) model[i] = '0;
        sb.delete();
    endtask

    // Monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_enable) begin
                en_cnt++;
                en_addr = mem_add;
                en_data = mem_write;
            end
            if (err) err_cnt++;
            if (32'(mem_add) >= L) bad_addr++;
            if (rd_valid && !rv_prev) rv_cnt++;
            if (rd_valid && rd_ready) begin
                if (sb.size() == 0) check_eq("rd_unexpected", 32'(sb.size()), 32'd1);
                else check_eq("rd_data", 32'(rd_data), 32'(sb.pop_front()));
            end
        end
        rv_prev = rd_valid;
    end

    task automatic do_write(input logic [3:0] a, input logic [W:0] d);
        int unsigned n;
        n = 0;
        @(negedge clk);
        wr_valid = 1'b1; wr_addr = a; wr_data = d;
        #1;
        while (!wr_ready && n < 20) begin @(negedge clk); #1; n++; end
        check_eq("wr_accept", 32'(wr_ready), 32'd1);
        @(posedge clk);
        if (32'(a) < L && d != '0) model[a] = d;
        #1 wr_valid = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] a);
        int unsigned n;
        n = 0;
        @(negedge clk);
        rd_req_valid = 1'b1; rd_addr = a;
        #1;
        while (!rd_req_ready && n < 20) begin @(negedge clk); #1; n++; end
        check_eq("rd_accept", 32'(rd_req_ready), 32'd1);
        @(posedge clk);
        if (32'(a) < L) sb.push_back(model[a]);
        #1 rd_req_valid = 1'b0;
    endtask

    task automatic wait_resp();
        int unsigned n;
        n = 0;
        while (sb.size() != 0 && n < 20) begin @(negedge clk); #1; n++; end
        if (sb.size() != 0) check_eq("resp_timeout", 32'(sb.size()), 32'd0);
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({wr_ready, rd_req_ready, rd_valid, err, mem_enable, rd_data, mem_write, mem_add});
    endfunction

    initial begin
        int unsigned lat, rv0;
        logic [W:0]  hold;
        reset = 1'b1;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        rd_req_valid = 1'b0; rd_addr = '0; rd_ready = 1'b1;
        clear_model();

        // Reset state
        repeat (2) @(negedge clk);
        #1 check_eq("reset_outputs", all_outs(), 32'd0);
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1 check_eq("ready_after_reset", 32'(wr_ready), 32'd1);

        // Write 0x5A to 3, read it back
        en_cnt = 0;
        do_write(4'd3, 8'h5A);
        repeat (3) @(negedge clk);
        check_eq("wr_en_cycles", en_cnt, 32'd1);
        check_eq("wr_en_addr", 32'(en_addr), 32'd3);
        check_eq("wr_en_data", 32'(en_data), 32'h5A);
        do_read(4'd3);
        lat = 1;
        while (!rd_valid && lat < 10) begin
            @(negedge clk);
            if (!rd_valid) lat++;
        end
        check_eq("rd_latency", lat, 32'd3);
        wait_resp();

        // Simultaneous write and read in IDLE
        @(negedge clk);
        wr_valid = 1'b1; wr_addr = 4'd2; wr_data = 8'h11;
        rd_req_valid = 1'b1; rd_addr = 4'd2;
        #1;
        check_eq("prio_wr_ready", 32'(wr_ready), 32'd1);
        check_eq("prio_rd_blocked", 32'(rd_req_ready), 32'd0);
        @(posedge clk);
        model[2] = 8'h11;
        #1 wr_valid = 1'b0;
        lat = 0;
        while (!rd_req_ready && lat < 20) begin @(negedge clk); #1; lat++; end
        check_eq("prio_rd_accept", 32'(rd_req_ready), 32'd1);
        @(posedge clk);
        sb.push_back(model[2]);
        #1 rd_req_valid = 1'b0;
        wait_resp();

        // Dropped requests
        en_cnt = 0; rv0 = rv_cnt;
        err_cnt = 0; do_write(4'd4, 8'h00); repeat (3) @(negedge clk);
        check_eq("err_zero_data", err_cnt, 32'd1);
        err_cnt = 0; do_write(4'd12, 8'h77); repeat (3) @(negedge clk);
        check_eq("err_wr_addr", err_cnt, 32'd1);
        err_cnt = 0; do_read(4'd15); repeat (4) @(negedge clk);
        check_eq("err_rd_addr", err_cnt, 32'd1);
        check_eq("err_no_enable", en_cnt, 32'd0);
        check_eq("err_no_resp", rv_cnt, rv0);

        // Response backpressure
        rd_ready = 1'b0;
        do_read(4'd5);
        repeat (3) @(negedge clk);
        #1;
        hold = rd_data;
        check_eq("bp_valid_rise", 32'(rd_valid), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check_eq("bp_valid", 32'(rd_valid), 32'd1);
            check_eq("bp_data", 32'(rd_data), 32'(hold));
            check_eq("bp_wr_ready", 32'(wr_ready), 32'd0);
            check_eq("bp_rd_req_ready", 32'(rd_req_ready), 32'd0);
            @(negedge clk); #1;
        end
        @(posedge clk);
        #1 rd_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("bp_idle", 32'(wr_ready), 32'd1);
        check_eq("bp_popped", 32'(sb.size()), 32'd0);

        // Fill and read back
        for (int i = 0; i < 10; i++) do_write(4'(i), 8'(i + 1));
        for (int i = 0; i < 10; i++) begin
            do_read(4'(i));
            wait_resp();
        end

        // Reset during READ
        do_read(4'd4);
        reset = 1'b1;
        #1 check_eq("rst_read_outputs", all_outs(), 32'd0);
        clear_model();
        rv0 = rv_cnt;
        @(negedge clk) reset = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("rst_read_no_resp", rv_cnt, rv0);
        do_read(4'd4);
        wait_resp();

        // Reset during WRITE
        do_write(4'd7, 8'h33);
        check_eq("in_write_enable", 32'(mem_enable), 32'd1);
        reset = 1'b1;
        #1 check_eq("rst_write_enable", 32'(mem_enable), 32'd0);
        clear_model();
        @(negedge clk) reset = 1'b0;
        #1 check_eq("rst_write_ready_low", 32'(wr_ready), 32'd0);
        @(posedge clk);
        #1 check_eq("rst_write_ready", 32'(wr_ready), 32'd1);
        do_read(4'd7);
        wait_resp();

        repeat (2) @(negedge clk);
        check_eq("mem_add_range", bad_addr, 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
